// File: rtl/mem_bus_arbiter.sv
// Purpose: shares the byte-wide memory/IO bus between instruction fetch and load/store.
// Latency: an N-byte read is done N+2 edges after the request is sampled; an N-byte write is done N+1 edges after.
// Backpressure: rdy_in low freezes all state; IO writes stall while io_buffer_full; a requester holds req until its done pulse.
module mem_bus_arbiter #(
    parameter int LS_BURST = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [2:0]        ls_len,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic              refresh_in,
    output logic              busy_out
);

    localparam int CNT_W = $clog2(LS_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LS_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched transaction context
    logic              owner_ls;    // 1 = load/store owns the bus, 0 = fetch
    logic [ADDR_W-1:0] base;
    logic [2:0]        len;         // 1, 2 or 4
    logic [2:0]        k;           // byte index; in RD it runs one past len to drain the last byte
    logic              wr_flag;
    logic [31:0]       wdata;
    logic [31:0]       rbuf;        // partially assembled read word
    logic [31:0]       if_data_q;
    logic [31:0]       ls_rdata_q;
    logic [CNT_W-1:0]  burst_cnt;

    // Decode helpers
    logic              force_if;
    logic              grant_ls;
    logic              grant_any;
    logic [2:0]        ls_len_n;
    logic [ADDR_W-1:0] cur_addr;
    logic              io_stall;
    logic              wr_issue;
    logic              abort;
    logic [1:0]        k_prev;
    logic [31:0]       rd_word;

    // Grant decision, length normalisation and per-cycle bus conditions
    always_comb begin
        force_if  = if_req && (burst_cnt == BURST_MAX);
        grant_ls  = ls_req && !force_if;
        grant_any = (ls_req || if_req) && !refresh_in;
        ls_len_n  = ((ls_len == 3'd1) || (ls_len == 3'd2)) ? ls_len : 3'd4;
        cur_addr  = base + ADDR_W'(k);
        io_stall  = (cur_addr[17:16] == 2'b11) && io_buffer_full;
        wr_issue  = (state == WR) && !io_stall;
        // Committed stores are never aborted; everything else in RD/DONE is.
        abort     = refresh_in &&
                    ((state == RD) || ((state == DONE) && !(owner_ls && wr_flag)));
    end

    // Merge the byte arriving this cycle (for offset k-1) into the read word
    always_comb begin
        k_prev  = k[1:0] - 2'd1;
        rd_word = rbuf;
        if (k != 3'd0) begin
            rd_word[{k_prev, 3'b000} +: 8] = mem_din;
        end
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a paused core holds its state
    always_comb begin
        state_nxt = state;
        if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state_nxt = (grant_ls && ls_wr) ? WR : RD;
                    end
                end
                RD: begin
                    if (refresh_in) begin
                        state_nxt = IDLE;
                    end else if (k == len) begin
                        state_nxt = DONE;
                    end
                end
                WR: begin
                    if (wr_issue && (k == len - 3'd1)) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: grant latching, byte stepping, read assembly and anti-starvation counter
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            owner_ls   <= 1'b0;
            base       <= '0;
            len        <= 3'd0;
            k          <= 3'd0;
            wr_flag    <= 1'b0;
            wdata      <= '0;
            rbuf       <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            burst_cnt  <= '0;
        end else if (rdy_in) begin
            if (refresh_in) begin
                burst_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_ls  <= grant_ls;
                        base      <= grant_ls ? ls_addr : if_addr;
                        len       <= grant_ls ? ls_len_n : 3'd4;
                        wr_flag   <= grant_ls && ls_wr;
                        wdata     <= ls_wdata;
                        k         <= 3'd0;
                        rbuf      <= '0;
                        // Only consecutive LS wins over a waiting fetch are counted
                        burst_cnt <= (grant_ls && if_req) ? burst_cnt + 1'b1 : '0;
                    end
                end
                RD: begin
                    rbuf <= rd_word;
                    k    <= k + 3'd1;
                    if ((k == len) && !refresh_in) begin
                        if (owner_ls) begin
                            ls_rdata_q <= rd_word;
                        end else begin
                            if_data_q <= rd_word;
                        end
                    end
                end
                WR: begin
                    if (wr_issue) begin
                        k <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus and handshake outputs decoded from the current state
    always_comb begin
        mem_a    = '0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        if_done  = 1'b0;
        ls_done  = 1'b0;
        case (state)
            RD: begin
                // The drain cycle parks the bus on address 0 so no IO location is read twice.
                if (k < len) begin
                    mem_a = cur_addr;
                end
            end
            WR: begin
                // A stalled IO write also parks the bus so the UART sees no stray read.
                if (!io_stall) begin
                    mem_a    = cur_addr;
                    mem_dout = wdata[{k[1:0], 3'b000} +: 8];
                    mem_wr   = rdy_in;
                end
            end
            DONE: begin
                if_done = rdy_in && !abort && !owner_ls;
                ls_done = rdy_in && !abort && owner_ls;
            end
            default: ;
        endcase
        if_data  = if_data_q;
        ls_rdata = ls_rdata_q;
        busy_out = (state != IDLE);
    end

endmodule
